// File: rtl/crop_window_gen_if.sv
// Pixel-stream bundle between the Y-start detector, the crop window stage and the capture path.
// master drives the raster side; slave is the crop window stage itself.
interface crop_window_gen_if;
  logic [9:0]  iDATA;
  logic        iDVAL;
  logic [15:0] iYSTART;
  logic [9:0]  oDATA;
  logic        oDVAL;
  logic [15:0] oX;
  logic [15:0] oY;
  logic [15:0] oYSTART_LAT;
  logic        oFRAME_DONE;

  modport master (
    output iDATA, iDVAL, iYSTART,
    input  oDATA, oDVAL, oX, oY, oYSTART_LAT, oFRAME_DONE
  );

  modport slave (
    input  iDATA, iDVAL, iYSTART,
    output oDATA, oDVAL, oX, oY, oYSTART_LAT, oFRAME_DONE
  );
endinterface

// File: rtl/crop_window_gen.sv
// Crop window stage: forwards the CROP_W x CROP_H window whose top row is the Y start latched at frame start.
// Optional macro CROP_BORDER_MARK_EN paints the window border with 10'h3FF as an alignment aid.
module crop_window_gen #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CROP_X0 = 160,
  parameter int CROP_W  = 320,
  parameter int CROP_H  = 240
) (
  input  logic                iCLK,
  input  logic                iRST,
  crop_window_gen_if.slave    bus
);

  localparam logic [15:0] X_WRAP      = 16'(IMG_W - 1);
  localparam logic [15:0] Y_WRAP      = 16'(IMG_H - 1);
  localparam logic [15:0] X_FIRST     = 16'(CROP_X0);
  localparam logic [15:0] X_LAST      = 16'(CROP_X0 + CROP_W - 1);
  localparam logic [15:0] START_MAX   = 16'(IMG_H - CROP_H);
  localparam logic [15:0] ROWS_LAST   = 16'(CROP_H - 1);
  localparam logic [15:0] WIN_X_LAST  = 16'(CROP_W - 1);

  typedef enum logic [1:0] {
    WAIT_TOP = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t      stateReg;
  logic [15:0] xCntReg;
  logic [15:0] yCntReg;
  logic [15:0] startLatReg;
  logic [9:0]  dataReg;
  logic        dvalReg;
  logic [15:0] winXReg;
  logic [15:0] winYReg;
  logic        frameDoneReg;

  logic        lineEnd;
  logic        frameEnd;
  logic        frameStart;
  logic [15:0] clampedStart;
  logic [15:0] startCur;
  logic        enterActive;
  logic        inWindow;
  logic        lastPix;
  logic [15:0] winX;
  logic [15:0] winY;
  logic [9:0]  pixOut;

  always_comb begin
    lineEnd      = (xCntReg == X_WRAP);
    frameEnd     = lineEnd && (yCntReg == Y_WRAP);
    frameStart   = (xCntReg == 16'd0) && (yCntReg == 16'd0);
    clampedStart = (bus.iYSTART > START_MAX) ? START_MAX : bus.iYSTART;
    // On the first pixel the freshly sampled start must already steer the FSM,
    // otherwise a start of 0 would miss its own top row.
    startCur     = frameStart ? clampedStart : startLatReg;
    enterActive  = (stateReg == WAIT_TOP) && (yCntReg == startCur);
    inWindow     = ((stateReg == ACTIVE) || enterActive) &&
                   (xCntReg >= X_FIRST) && (xCntReg <= X_LAST);
    winX         = xCntReg - X_FIRST;
    winY         = yCntReg - startCur;
    lastPix      = inWindow && (xCntReg == X_LAST) && (yCntReg == startCur + ROWS_LAST);
    pixOut       = bus.iDATA;
`ifdef CROP_BORDER_MARK_EN
    if ((winX == 16'd0) || (winX == WIN_X_LAST) || (winY == 16'd0) || (winY == ROWS_LAST)) begin
      pixOut = 10'h3FF;
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg     <= WAIT_TOP;
      xCntReg      <= 16'd0;
      yCntReg      <= 16'd0;
      startLatReg  <= 16'd0;
      dataReg      <= 10'd0;
      dvalReg      <= 1'b0;
      winXReg      <= 16'd0;
      winYReg      <= 16'd0;
      frameDoneReg <= 1'b0;
    end else begin
      dvalReg      <= 1'b0;
      frameDoneReg <= 1'b0;
      if (bus.iDVAL) begin
        if (lineEnd) begin
          xCntReg <= 16'd0;
          yCntReg <= frameEnd ? 16'd0 : yCntReg + 16'd1;
        end else begin
          xCntReg <= xCntReg + 16'd1;
        end

        if (frameStart) begin
          startLatReg <= clampedStart;
        end

        case (stateReg)
          WAIT_TOP: if (enterActive) stateReg <= lastPix ? DONE : ACTIVE;
          ACTIVE:   if (lastPix) stateReg <= DONE;
          default:  ;
        endcase
        // The wrap pixel always rearms for the next frame, even if it was the last window pixel.
        if (frameEnd) begin
          stateReg <= WAIT_TOP;
        end

        if (inWindow) begin
          dvalReg      <= 1'b1;
          dataReg      <= pixOut;
          winXReg      <= winX;
          winYReg      <= winY;
          frameDoneReg <= lastPix;
        end
      end
    end
  end

  assign bus.oDATA       = dataReg;
  assign bus.oDVAL       = dvalReg;
  assign bus.oX          = winXReg;
  assign bus.oY          = winYReg;
  assign bus.oYSTART_LAT = startLatReg;
  assign bus.oFRAME_DONE = frameDoneReg;

endmodule

// File: tb/tb_crop_window_gen.sv
// Directed bench for crop_window_gen on a scaled-down 16x12 raster with an 8x6 window at column 4.
// Honours CROP_BORDER_MARK_EN the same way the design does when it is defined for the build.
module tb_crop_window_gen;

  localparam int TW  = 16;
  localparam int TH  = 12;
  localparam int TX0 = 4;
  localparam int TCW = 8;
  localparam int TCH = 6;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  int errorCount = 0;
  int checkCount = 0;
  int dvalCount;
  int doneCount;

  logic [9:0]  holdData;
  logic [15:0] holdX;
  logic [15:0] holdY;

  crop_window_gen_if cropBus ();

  crop_window_gen #(
    .IMG_W   (TW),
    .IMG_H   (TH),
    .CROP_X0 (TX0),
    .CROP_W  (TCW),
    .CROP_H  (TCH)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (cropBus)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [9:0] pixVal(input int x, input int y, input int seed, input bit flat);
    int v;
    v = (x * 7 + y * 31 + seed * 13) % 1024;
    return flat ? 10'h055 : 10'(v);
  endfunction

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_dval"}, 32'(cropBus.oDVAL), 32'd0);
    checkVal({tag, "_data"}, 32'(cropBus.oDATA), 32'd0);
    checkVal({tag, "_x"},    32'(cropBus.oX), 32'd0);
    checkVal({tag, "_y"},    32'(cropBus.oY), 32'd0);
    checkVal({tag, "_lat"},  32'(cropBus.oYSTART_LAT), 32'd0);
    checkVal({tag, "_done"}, 32'(cropBus.oFRAME_DONE), 32'd0);
  endtask

  task automatic pulseReset(input string tag);
    iRST = 1'b1;
    cropBus.iDVAL = 1'b1;
    cropBus.iDATA = 10'h3FF;
    @(posedge iCLK); #1;
    checkAllZero(tag);
    holdData = 10'd0;
    holdX    = 16'd0;
    holdY    = 16'd0;
    iRST = 1'b0;
    cropBus.iDVAL = 1'b0;
  endtask

  task automatic stepPixel(input logic dval, input logic [9:0] data, input bit expIn,
                           input logic [9:0] expData, input int wx, input int wy,
                           input bit expDone, input int expLat, input bit checkLat);
    cropBus.iDVAL = dval;
    cropBus.iDATA = data;
    @(posedge iCLK); #1;
    if (expIn) begin
      holdData = expData;
      holdX    = 16'(wx);
      holdY    = 16'(wy);
    end
    dvalCount += int'(cropBus.oDVAL);
    doneCount += int'(cropBus.oFRAME_DONE);
    checkVal("dval", 32'(cropBus.oDVAL), 32'(expIn));
    checkVal("data", 32'(cropBus.oDATA), 32'(holdData));
    checkVal("x",    32'(cropBus.oX), 32'(holdX));
    checkVal("y",    32'(cropBus.oY), 32'(holdY));
    checkVal("done", 32'(cropBus.oFRAME_DONE), 32'(expDone));
    if (checkLat) checkVal("ystart_lat", 32'(cropBus.oYSTART_LAT), 32'(expLat));
    cropBus.iDVAL = 1'b0;
  endtask

  // stopRow >= 0 abandons the frame at the start of that row (used before a mid-frame reset).
  task automatic runFrame(input int ystart, input int expStart, input bit gaps, input bit flat,
                          input int seed, input int midRow, input int midVal, input int stopRow);
    bit inW;
    bit lastW;
    int wx;
    int wy;
    logic [9:0] d;
    logic [9:0] e;
    dvalCount = 0;
    doneCount = 0;
    cropBus.iYSTART = 16'(ystart);
    for (int y = 0; y < TH; y++) begin
      if (y == stopRow) begin
        $display("partial frame ystart=%0d stopped at row %0d dvals=%0d", ystart, y, dvalCount);
        return;
      end
      for (int x = 0; x < TW; x++) begin
        if (y == midRow && x == 0) cropBus.iYSTART = 16'(midVal);
        if (gaps) stepPixel(1'b0, 10'h2AA, 1'b0, 10'd0, 0, 0, 1'b0, 0, 1'b0);
        inW   = (y >= expStart) && (y < expStart + TCH) && (x >= TX0) && (x < TX0 + TCW);
        wx    = x - TX0;
        wy    = y - expStart;
        lastW = inW && (wx == TCW - 1) && (wy == TCH - 1);
        d     = pixVal(x, y, seed, flat);
        e     = d;
`ifdef CROP_BORDER_MARK_EN
        if (wx == 0 || wx == TCW - 1 || wy == 0 || wy == TCH - 1) e = 10'h3FF;
`endif
        stepPixel(1'b1, d, inW, e, wx, wy, lastW, expStart, 1'b1);
      end
    end
    checkVal("frame_dvals", 32'(dvalCount), 32'(TCW * TCH));
    checkVal("frame_done_count", 32'(doneCount), 32'd1);
    $display("frame ystart=%0d lat=%0d gaps=%0d dvals=%0d dones=%0d",
             ystart, cropBus.oYSTART_LAT, gaps, dvalCount, doneCount);
  endtask

  initial begin
    cropBus.iDVAL   = 1'b0;
    cropBus.iDATA   = 10'd0;
    cropBus.iYSTART = 16'd0;
    holdData = 10'd0;
    holdX    = 16'd0;
    holdY    = 16'd0;
    dvalCount = 0;
    doneCount = 0;

    repeat (2) @(posedge iCLK);
    pulseReset("reset");

    // Plain window at start row 3.
    runFrame(3, 3, 1'b0, 1'b0, 1, -1, 0, -1);
    // Start above the clamp limit: window pinned to the bottom rows 6..11.
    runFrame(9, 6, 1'b0, 1'b0, 2, -1, 0, -1);
    // Start 0 opens on the first row; a mid-frame change to 5 only applies next frame.
    runFrame(0, 0, 1'b0, 1'b0, 3, 2, 5, -1);
    // Next frame picks up 5, with an idle cycle in front of every pixel.
    runFrame(5, 5, 1'b1, 1'b0, 4, -1, 0, -1);
    // Flat data exposes the border marking when enabled.
    runFrame(2, 2, 1'b0, 1'b1, 5, -1, 0, -1);
    // Reset in the middle of the window rows, then a full frame from (0,0).
    runFrame(4, 4, 1'b0, 1'b0, 6, -1, 0, 6);
    pulseReset("midreset");
    runFrame(1, 1, 1'b0, 1'b0, 7, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
